// File: rtl/multi_cycle_subtractor.sv
// multi_cycle_subtractor
//
// Computes Diff = A - B - Bin over a WIDTH-bit operand, CHUNK bits per clock.
// The borrow between chunks lives in a register, so the critical path is one
// CHUNK-bit ripple instead of the full WIDTH.
//
// Ports:
//   Clk     rising-edge clock
//   Reset   asynchronous, active-high reset
//   Start   request, accepted only while Busy=0
//   A, B    minuend / subtrahend (WIDTH bits), latched on accept
//   Bin     borrow-in to bit 0, latched on accept
//   Enable  latched on accept; 0 reports Diff as zero
//   Busy    high while an operation is in progress
//   Valid   one-cycle pulse when Diff/Bout/Zero update
//   Diff    registered result
//   Bout    registered borrow-out of the MSB
//   Zero    high when the reported Diff is all zeros
//
// Optional feature: define SUB_SATURATE_EN to clamp Diff to zero when the
// final borrow is set (Enable=1 only). Bout still reports the true borrow.

module multi_cycle_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             Enable,
  output logic             Busy,
  output logic             Valid,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, part_q;
  logic             en_q, borrow_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q, valid_q;

  logic             accept, last;
  logic [CHUNK-1:0] a_chunk, b_chunk, d_chunk;
  logic [CHUNK:0]   bw;
  logic [WIDTH-1:0] part_next, rep;
  int unsigned      base;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StBusy;
      StBusy:  if (last)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    Busy   = (state_q == StBusy);
    accept = (state_q == StIdle) && Start;
    last   = (state_q == StBusy) && (idx_q == IdxW'(N - 1));
    Valid  = valid_q;
    Diff   = diff_q;
    Bout   = bout_q;
    Zero   = zero_q;
  end

  // One chunk of ripple subtraction seeded by the borrow register
  always_comb begin
    base    = 32'(idx_q) * CHUNK;
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    bw      = '0;
    d_chunk = '0;
    bw[0]   = borrow_q;
    for (int k = 0; k < CHUNK; k++) begin
      d_chunk[k] = a_chunk[k] ^ b_chunk[k] ^ bw[k];
      bw[k+1]    = (~a_chunk[k] & b_chunk[k]) | (~(a_chunk[k] ^ b_chunk[k]) & bw[k]);
    end
    part_next = part_q;
    part_next[base +: CHUNK] = d_chunk;
`ifdef SUB_SATURATE_EN
    rep = (!en_q || bw[CHUNK]) ? '0 : part_next;
`else
    rep = en_q ? part_next : '0;
`endif
  end

  // Datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      en_q     <= 1'b0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        a_q      <= A;
        b_q      <= B;
        en_q     <= Enable;
        borrow_q <= Bin;
        idx_q    <= '0;
      end else if (state_q == StBusy) begin
        part_q   <= part_next;
        borrow_q <= bw[CHUNK];
        if (last) begin
          idx_q   <= '0;
          diff_q  <= rep;
          bout_q  <= bw[CHUNK];
          zero_q  <= (rep == '0);
          valid_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_subtractor.sv
// Self-checking bench for multi_cycle_subtractor: directed cases with literal
// expectations plus randomized traffic compared every cycle against an
// arithmetic reference model.

module tb_multi_cycle_subtractor;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;
  localparam int unsigned N = W / C;

  logic         Clk = 1'b0;
  logic         Reset, Start, Bin, Enable;
  logic [W-1:0] A, B;
  logic         Busy, Valid, Bout, Zero;
  logic [W-1:0] Diff;

  int n_tests = 0;
  int n_fail  = 0;

  multi_cycle_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Enable(Enable),
    .Busy  (Busy),
    .Valid (Valid),
    .Diff  (Diff),
    .Bout  (Bout),
    .Zero  (Zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {bout, zero, diff} straight from the arithmetic definition.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin, input logic en);
    logic [W:0]   rhs;
    logic         bo;
    logic [W-1:0] d;
    rhs = {1'b0, b} + (W+1)'(bin);
    bo  = ({1'b0, a} < rhs);
    d   = a - b - W'(bin);
    if (!en) d = '0;
`ifdef SUB_SATURATE_EN
    if (bo) d = '0;
`endif
    return {bo, (d == '0), d};
  endfunction

  // Reference model: an accepted request yields its result N clocks later.
  int           m_cnt;
  logic [W-1:0] m_a, m_b, m_diff;
  logic         m_bin, m_en, m_bout, m_zero, m_valid;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_cnt <= 0; m_a <= '0; m_b <= '0; m_bin <= 1'b0; m_en <= 1'b0;
      m_diff <= '0; m_bout <= 1'b0; m_zero <= 1'b0; m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_cnt == 0) begin
        if (Start) begin
          m_a <= A; m_b <= B; m_bin <= Bin; m_en <= Enable;
          m_cnt <= N;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_bout, m_zero, m_diff} <= ref_sub(m_a, m_b, m_bin, m_en);
          m_valid <= 1'b1;
        end
      end
    end
  end

  // Compare process: every output, every cycle
  always @(negedge Clk) begin
    check("model_busy",  32'(Busy),  32'(m_cnt != 0));
    check("model_valid", 32'(Valid), 32'(m_valid));
    check("model_diff",  32'(Diff),  32'(m_diff));
    check("model_bout",  32'(Bout),  32'(m_bout));
    check("model_zero",  32'(Zero),  32'(m_zero));
  end

  task automatic wait_valid(input string nm, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (Valid) got = 1'b1;
      else begin
        lat++;
        @(negedge Clk);
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no Valid expected Valid within 12 cycles", nm);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic en, input logic [W-1:0] ed, input logic eb,
                       input logic ez, input string nm);
    int lat;
    @(negedge Clk); #1;
    Start = 1'b1; A = a; B = b; Bin = bin; Enable = en;
    @(negedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    wait_valid(nm, lat);
    check({nm, "_lat"},  32'(lat + 1), 32'(N));
    check({nm, "_diff"}, 32'(Diff), 32'(ed));
    check({nm, "_bout"}, 32'(Bout), 32'(eb));
    check({nm, "_zero"}, 32'(Zero), 32'(ez));
    check({nm, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int lat;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0; Enable = 1'b0;

    // Start pulsed during reset must not start anything
    repeat (2) @(negedge Clk);
    #1 Start = 1'b1;
    repeat (2) @(negedge Clk);
    check("rst_busy",  32'(Busy),  32'd0);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_diff",  32'(Diff),  32'd0);
    check("rst_bout",  32'(Bout),  32'd0);
    check("rst_zero",  32'(Zero),  32'd0);
    #1 Start = 1'b0; Reset = 1'b0;

    do_op(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, "basic");
`ifdef SUB_SATURATE_EN
    do_op(16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "underflow");
`else
    do_op(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, "underflow");
`endif
    do_op(16'h1000, 16'h0000, 1'b1, 1'b1, 16'h0FFF, 1'b0, 1'b0, "ripple");
    do_op(16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, "equal");

    // Start held high: operand changes during BUSY are ignored, restart at T5
    @(negedge Clk); #1;
    Start = 1'b1; A = 16'h0001; B = 16'h0000; Bin = 1'b0; Enable = 1'b1;
    @(negedge Clk); #1;
    A = 16'h0007; B = 16'h0002;
    @(negedge Clk);
    wait_valid("held1", lat);
    check("held1_diff", 32'(Diff), 32'h1);
    @(negedge Clk);
    check("held_restart_busy",  32'(Busy),  32'd1);
    check("held_restart_valid", 32'(Valid), 32'd0);
    #1 Start = 1'b0;
    wait_valid("held2", lat);
    check("held2_diff", 32'(Diff), 32'h5);

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, "disabled");

    // Reset in the middle of an operation
    @(negedge Clk); #1;
    Start = 1'b1; A = 16'h1234; B = 16'h0001; Bin = 1'b0; Enable = 1'b1;
    @(negedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("midrst_busy",  32'(Busy),  32'd0);
    check("midrst_valid", 32'(Valid), 32'd0);
    check("midrst_diff",  32'(Diff),  32'd0);
    check("midrst_zero",  32'(Zero),  32'd0);
    @(negedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("midrst_no_valid", 32'(Valid), 32'd0);
    end
    do_op(16'd9, 16'd4, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, "after_rst");

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 800; i++) begin
      @(negedge Clk); #1;
      Reset  = ($urandom_range(0, 149) == 0);
      Start  = ($urandom_range(0, 2) != 0);
      A      = W'($urandom);
      B      = ($urandom_range(0, 7) == 0) ? A : W'($urandom);
      Bin    = 1'($urandom);
      Enable = ($urandom_range(0, 3) != 0);
    end
    @(negedge Clk); #1;
    Reset = 1'b0; Start = 1'b0;
    repeat (2 * N + 2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
